// File: rtl/fx2_arb_pkg.sv
// Shared state encoding and defaults for the FX2 two-channel stream arbiter.
package fx2_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_WRITE  = 3'd2,
    ST_COMMIT = 3'd3,
    ST_GAP    = 3'd4
  } fx2_arb_state_e;

  localparam logic [1:0] FADDR_EP6         = 2'b10;
  localparam logic [1:0] FADDR_EP8         = 2'b11;
  localparam int         PKT_WORDS_DEFAULT = 256;

endpackage

// File: rtl/fx2_rr_grant.sv
// Two-requester round-robin decision; the last-served register is updated by the owner FSM.
module fx2_rr_grant (
  input  logic clk_out_0,
  input  logic reset_n,
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic update_i,
  input  logic served_b_i,
  output logic pick_b_o
);

  // Resets to "B served last" so that A wins the first contested decision.
  logic last_b_q;

  always_ff @(posedge clk_out_0 or negedge reset_n) begin
    if (!reset_n) begin
      last_b_q <= 1'b1;
    end else if (update_i) begin
      last_b_q <= served_b_i;
    end
  end

  always_comb begin
    pick_b_o = 1'b0;
    if (req_a_i && req_b_i) begin
      pick_b_o = !last_b_q;
    end else if (req_b_i) begin
      pick_b_o = 1'b1;
    end
  end

endmodule

// File: rtl/fx2_stream_arbiter.sv
// Arbitrates two 16-bit word streams onto an FX2 slave FIFO in PKT_WORDS-word packets.
// Optional short-packet commit via pkt_end is enabled by defining FX2_ARB_PKTEND_EN.
module fx2_stream_arbiter
  import fx2_arb_pkg::*;
#(
  parameter int         PKT_WORDS = PKT_WORDS_DEFAULT,
  parameter logic [1:0] FADDR_A   = FADDR_EP6,
  parameter logic [1:0] FADDR_B   = FADDR_EP8
) (
  input  logic           clk_out_0,
  input  logic           reset_n,
  input  logic           a_valid,
  input  logic           a_last,
  input  logic [15:0]    a_data,
  output logic           a_ready,
  input  logic           b_valid,
  input  logic           b_last,
  input  logic [15:0]    b_data,
  output logic           b_ready,
  input  logic           flag_full_n,
  output logic [15:0]    fdata,
  output logic [1:0]     faddr,
  output logic           slwr,
  output logic           slrd,
  output logic           sloe,
  output logic           pkt_end,
  output logic           grant,
  output logic           busy,
  output fx2_arb_state_e dbg_state_o
);

  localparam int             CW       = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(PKT_WORDS - 1);

  fx2_arb_state_e state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           grant_q, grant_d;
  logic [1:0]     faddr_q, faddr_d;
  logic [15:0]    fdata_q, fdata_d;
  logic           slwr_q, slwr_d;
  logic           sel_valid;
  logic [15:0]    sel_data;
  logic           accept;
  logic           rr_pick_b;
  logic           rr_update;

  fx2_rr_grant u_rr (
    .clk_out_0  (clk_out_0),
    .reset_n    (reset_n),
    .req_a_i    (a_valid),
    .req_b_i    (b_valid),
    .update_i   (rr_update),
    .served_b_i (grant_q),
    .pick_b_o   (rr_pick_b)
  );

  // Handshake: a word moves on the rising edge where valid && ready. Ready is
  // combinational (granted valid & flag_full_n, WRITE only); the source must hold
  // data/last stable while valid is high and not yet accepted.
  always_comb begin
    sel_valid = grant_q ? b_valid : a_valid;
    sel_data  = grant_q ? b_data  : a_data;
    accept    = (state_q == ST_WRITE) && sel_valid && flag_full_n;
    a_ready   = accept && !grant_q;
    b_ready   = accept && grant_q;
  end

`ifdef FX2_ARB_PKTEND_EN
  logic sel_last;
  logic pkt_end_q, pkt_end_d;
  assign sel_last = grant_q ? b_last : a_last;
  assign pkt_end  = pkt_end_q;
`else
  logic unused_last;
  assign unused_last = a_last | b_last;
  assign pkt_end     = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    faddr_d   = faddr_q;
    fdata_d   = fdata_q;
    slwr_d    = 1'b1;
    rr_update = 1'b0;
`ifdef FX2_ARB_PKTEND_EN
    pkt_end_d = 1'b1;
`endif
    case (state_q)
      ST_IDLE: begin
        if (a_valid || b_valid) begin
          grant_d = rr_pick_b;
          faddr_d = rr_pick_b ? FADDR_B : FADDR_A;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_WRITE;
      ST_WRITE: begin
        if (accept) begin
          fdata_d = sel_data;
          slwr_d  = 1'b0;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_GAP;
          end
`ifdef FX2_ARB_PKTEND_EN
          else if (sel_last) begin
            cnt_d   = '0;
            state_d = ST_COMMIT;
          end
`endif
          else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      // Registered pulse lands on the cycle after the final slwr low.
      ST_COMMIT: begin
`ifdef FX2_ARB_PKTEND_EN
        pkt_end_d = 1'b0;
`endif
        state_d = ST_GAP;
      end
      ST_GAP: begin
        rr_update = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_out_0 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      grant_q <= 1'b0;
      faddr_q <= FADDR_A;
      fdata_q <= 16'h0000;
      slwr_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      faddr_q <= faddr_d;
      fdata_q <= fdata_d;
      slwr_q  <= slwr_d;
    end
  end

`ifdef FX2_ARB_PKTEND_EN
  always_ff @(posedge clk_out_0 or negedge reset_n) begin
    if (!reset_n) begin
      pkt_end_q <= 1'b1;
    end else begin
      pkt_end_q <= pkt_end_d;
    end
  end
`endif

  assign fdata       = fdata_q;
  assign faddr       = faddr_q;
  assign slwr        = slwr_q;
  assign slrd        = 1'b1;
  assign sloe        = 1'b1;
  assign grant       = grant_q;
  assign busy        = (state_q != ST_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fx2_stream_arbiter.sv
// Self-checking bench for fx2_stream_arbiter: directed scenarios plus randomized
// traffic scored against a packet-level reference model.
module tb_fx2_stream_arbiter;

  localparam int PW    = 4;
  localparam int EXP_W = 19;  // {commit, faddr[1:0], data[15:0]}
`ifdef FX2_ARB_PKTEND_EN
  localparam bit PKTEND_EN = 1'b1;
`else
  localparam bit PKTEND_EN = 1'b0;
`endif
  localparam logic [1:0] EP_A = 2'b10;
  localparam logic [1:0] EP_B = 2'b11;

  // ---------------- clock / reset ----------------
  logic        clk_out_0   = 1'b0;
  logic        reset_n     = 1'b0;
  logic        a_valid     = 1'b0;
  logic        a_last      = 1'b0;
  logic [15:0] a_data      = 16'h0;
  logic        a_ready;
  logic        b_valid     = 1'b0;
  logic        b_last      = 1'b0;
  logic [15:0] b_data      = 16'h0;
  logic        b_ready;
  logic        flag_full_n = 1'b1;
  logic [15:0] fdata;
  logic [1:0]  faddr;
  logic        slwr, slrd, sloe, pkt_end, grant, busy;
  fx2_arb_pkg::fx2_arb_state_e dbg_state;

  always #5 clk_out_0 = ~clk_out_0;

  fx2_stream_arbiter #(.PKT_WORDS(PW)) dut (
    .clk_out_0   (clk_out_0),
    .reset_n     (reset_n),
    .a_valid     (a_valid),
    .a_last      (a_last),
    .a_data      (a_data),
    .a_ready     (a_ready),
    .b_valid     (b_valid),
    .b_last      (b_last),
    .b_data      (b_data),
    .b_ready     (b_ready),
    .flag_full_n (flag_full_n),
    .fdata       (fdata),
    .faddr       (faddr),
    .slwr        (slwr),
    .slrd        (slrd),
    .sloe        (sloe),
    .pkt_end     (pkt_end),
    .grant       (grant),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  // ---------------- bench state ----------------
  int               n_checks = 0;
  int               n_errors = 0;
  logic [16:0]      src_a[$];
  logic [16:0]      src_b[$];
  logic [EXP_W-1:0] exp_q[$];
  int               exp_total = 0;
  int               wr_cyc[$];
  int               pe_cyc[$];
  int               rise_cyc[$];
  bit               busy_at[int];
  int               cyc = 0;
  bit               sb_on = 1'b0;
  bit               rand_mode = 1'b0;
  bit               pe_due = 1'b0;
  bit               busy_prev = 1'b0;
  int               full_hold = 0;
  int               hold_trigger = -1;
  int               acc_a = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive();
    bit          stall;
    logic [16:0] h;
    stall = rand_mode && ($urandom_range(0, 5) == 0);
    h = (src_a.size() != 0) ? src_a[0] : 17'h0;
    a_valid = (src_a.size() != 0) && !stall;
    a_data  = h[15:0];
    a_last  = h[16];
    h = (src_b.size() != 0) ? src_b[0] : 17'h0;
    b_valid = (src_b.size() != 0) && !stall;
    b_data  = h[15:0];
    b_last  = h[16];
    if (full_hold > 0) begin
      flag_full_n = 1'b0;
      full_hold--;
    end else begin
      flag_full_n = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  endtask

  // Called mid-cycle: outputs are settled, the coming rising edge commits handshakes.
  task automatic sample();
    logic [EXP_W-1:0] e;
    bit               pe_now;
    pe_now = 1'b0;
    cyc++;
    check("slrd_high", slrd, 1);
    check("sloe_high", sloe, 1);
    check("ready_exclusive", a_ready & b_ready, 0);
    if (!flag_full_n) check("ready_while_full", a_ready | b_ready, 0);
    if (!a_valid) check("a_ready_without_valid", a_ready, 0);
    if (!b_valid) check("b_ready_without_valid", b_ready, 0);
    busy_at[cyc] = busy;
    if (busy && !busy_prev) rise_cyc.push_back(cyc);
    busy_prev = busy;
    if (!slwr) begin
      wr_cyc.push_back(cyc);
      if (sb_on && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("write_word", {faddr, fdata}, e[17:0]);
        pe_now = e[18];
      end
    end
    if (!pkt_end) pe_cyc.push_back(cyc);
    if (sb_on) check("pkt_end", pkt_end, !pe_due);
    pe_due = pe_now;
    if (a_valid && a_ready) begin
      src_a.delete(0);
      acc_a++;
      if (acc_a == hold_trigger) full_hold = 3;
    end
    if (b_valid && b_ready) src_b.delete(0);
  endtask

  task automatic step();
    drive();
    @(negedge clk_out_0);
    sample();
    @(posedge clk_out_0);
    #1;
  endtask

  task automatic clear_logs();
    wr_cyc.delete();
    pe_cyc.delete();
    rise_cyc.delete();
    busy_at.delete();
    pe_due       = 1'b0;
    acc_a        = 0;
    hold_trigger = -1;
    full_hold    = 0;
    busy_prev    = 1'b0;
  endtask

  task automatic reset_dut();
    reset_n     = 1'b0;
    a_valid     = 1'b0;
    b_valid     = 1'b0;
    a_last      = 1'b0;
    b_last      = 1'b0;
    flag_full_n = 1'b1;
    src_a.delete();
    src_b.delete();
    exp_q.delete();
    repeat (2) @(posedge clk_out_0);
    @(negedge clk_out_0);
    reset_n = 1'b1;
    @(posedge clk_out_0);
    #1;
    clear_logs();
  endtask

  task automatic gen_packet(input bit ch);
    int          len;
    logic [16:0] w;
    len = PKTEND_EN ? int'($urandom_range(1, PW)) : PW;
    for (int i = 0; i < len; i++) begin
      w[15:0] = 16'($urandom);
      if (i == len - 1) w[16] = (len < PW) ? 1'b1 : 1'($urandom_range(0, 1));
      else              w[16] = PKTEND_EN ? 1'b0 : 1'($urandom_range(0, 1));
      if (ch) src_b.push_back(w);
      else    src_a.push_back(w);
    end
  endtask

  // ---------------- reference model ----------------
  // Packets end after PW words, or early on 'last' when short commit is enabled.
  // Channels alternate while both have data pending; A wins the first contest.
  task automatic build_expected();
    logic [16:0] qa[$];
    logic [16:0] qb[$];
    logic [16:0] w;
    bit          last_b;
    bit          pick_b;
    bit          short_pkt;
    qa = src_a;
    qb = src_b;
    last_b = 1'b1;
    exp_q.delete();
    while (qa.size() != 0 || qb.size() != 0) begin
      if (qa.size() != 0 && qb.size() != 0) pick_b = !last_b;
      else                                  pick_b = (qb.size() != 0);
      last_b = pick_b;
      for (int n = 1; n <= PW; n++) begin
        if (pick_b) w = qb.pop_front();
        else        w = qa.pop_front();
        short_pkt = PKTEND_EN && w[16] && (n < PW);
        exp_q.push_back({short_pkt, (pick_b ? EP_B : EP_A), w[15:0]});
        if (short_pkt) break;
        if (pick_b ? (qb.size() == 0) : (qa.size() == 0)) break;
      end
    end
    exp_total = exp_q.size();
  endtask

  task automatic run_sb(input int budget);
    int n;
    n = 0;
    sb_on = 1'b1;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check("drained_within_budget", exp_q.size(), 0);
    repeat (4) step();
    check("write_count", wr_cyc.size(), exp_total);
    sb_on = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    a_valid = 1'b1;
    b_valid = 1'b1;
    #12;
    check("rst_slwr", slwr, 1);
    check("rst_pkt_end", pkt_end, 1);
    check("rst_busy", busy, 0);
    check("rst_faddr", faddr, EP_A);
    check("rst_fdata", fdata, 0);
    check("rst_grant", grant, 0);
    check("rst_a_ready", a_ready, 0);
    check("rst_b_ready", b_ready, 0);

    // Single channel, one full packet.
    reset_dut();
    for (int i = 1; i <= 4; i++) src_a.push_back({1'b0, 16'(i)});
    build_expected();
    run_sb(60);
    check("t1_packets", rise_cyc.size(), 1);
    if (wr_cyc.size() == 4 && rise_cyc.size() >= 1) begin
      check("t1_setup_latency", wr_cyc[0] - rise_cyc[0], 2);
      check("t1_back_to_back", wr_cyc[3] - wr_cyc[0], 3);
      check("t1_gap_busy", busy_at[wr_cyc[3]], 1);
      check("t1_idle_after_gap", busy_at[wr_cyc[3] + 1], 0);
    end
    check("t1_no_pkt_end", pe_cyc.size(), 0);

    // Both channels contending: A, B, A.
    reset_dut();
    for (int i = 0; i < 8; i++) src_a.push_back({1'b0, 16'hA000 + 16'(i)});
    for (int i = 0; i < 4; i++) src_b.push_back({1'b0, 16'hB000 + 16'(i)});
    build_expected();
    run_sb(100);
    check("t2_packets", rise_cyc.size(), 3);
    if (wr_cyc.size() == 12 && rise_cyc.size() == 3) begin
      for (int k = 0; k < 3; k++) check("t2_one_setup_cycle", wr_cyc[4 * k] - rise_cyc[k], 2);
    end
    check("t2_no_pkt_end", pe_cyc.size(), 0);

    // FIFO full for 3 cycles after word 2.
    reset_dut();
    for (int i = 1; i <= 4; i++) src_a.push_back({1'b0, 16'(i)});
    hold_trigger = 2;
    build_expected();
    run_sb(60);
    if (wr_cyc.size() == 4) begin
      check("t3_w1_w2", wr_cyc[1] - wr_cyc[0], 1);
      check("t3_stall_gap", wr_cyc[2] - wr_cyc[1], 4);
      check("t3_w3_w4", wr_cyc[3] - wr_cyc[2], 1);
    end

    // 'last' on word 2, on a 4th word, and on word 2 again.
    reset_dut();
    src_a.push_back({1'b0, 16'h0001});
    src_a.push_back({1'b1, 16'h0002});
    src_a.push_back({1'b0, 16'h0003});
    src_a.push_back({1'b0, 16'h0004});
    src_a.push_back({1'b0, 16'h0005});
    src_a.push_back({1'b1, 16'h0006});
    src_a.push_back({1'b0, 16'h0007});
    src_a.push_back({1'b1, 16'h0008});
    build_expected();
    run_sb(100);
    check("t4_pkt_end_pulses", pe_cyc.size(), PKTEND_EN ? 2 : 0);
    check("t4_packets", rise_cyc.size(), PKTEND_EN ? 3 : 2);
    if (pe_cyc.size() != 0 && wr_cyc.size() >= 2) check("t4_pkt_end_timing", pe_cyc[0], wr_cyc[1] + 1);
    if (wr_cyc.size() == 8 && rise_cyc.size() >= 2)
      check("t4_next_pkt_start", wr_cyc[PKTEND_EN ? 2 : 4] - rise_cyc[1], 2);

    // Reset while word 3 is on the bus.
    reset_dut();
    for (int i = 1; i <= 8; i++) src_a.push_back({1'b0, 16'h0020 + 16'(i)});
    for (int i = 1; i <= 4; i++) src_b.push_back({1'b0, 16'h0050 + 16'(i)});
    begin
      int n;
      n = 0;
      while (wr_cyc.size() < 2 && n < 50) begin
        step();
        n++;
      end
    end
    check("t5_reached_word2", wr_cyc.size(), 2);
    check("t5_word3_on_bus", slwr, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_rst_slwr", slwr, 1);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_pkt_end", pkt_end, 1);
    check("t5_rst_a_ready", a_ready, 0);
    check("t5_rst_faddr", faddr, EP_A);
    check("t5_rst_fdata", fdata, 0);
    @(posedge clk_out_0);
    #3;
    reset_n = 1'b1;
    src_a.delete();
    src_b.delete();
    clear_logs();
    for (int i = 1; i <= 4; i++) src_a.push_back({1'b0, 16'h0030 + 16'(i)});
    for (int i = 1; i <= 4; i++) src_b.push_back({1'b0, 16'h0060 + 16'(i)});
    build_expected();
    run_sb(100);
    if (wr_cyc.size() == 8 && rise_cyc.size() >= 1)
      check("t5_full_first_pkt", wr_cyc[3] - wr_cyc[0], 3);

    // Randomized traffic with backpressure and source gaps.
    for (int r = 0; r < 4; r++) begin
      reset_dut();
      for (int p = 0; p < 5; p++) begin
        gen_packet(1'b0);
        gen_packet(1'b1);
      end
      build_expected();
      rand_mode = 1'b1;
      run_sb(3000);
      rand_mode = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fx2_stream_arbiter.md
FX2_STREAM_ARBITER -- requirements
Module: fx2_stream_arbiter

Interface
REQ-001 Parameter PKT_WORDS, default 256, sets the words per full USB packet (range 2..1024).
REQ-002 Parameter FADDR_A, default 2'b10, is the FIFO address (EP6) used for channel A.
REQ-003 Parameter FADDR_B, default 2'b11, is the FIFO address (EP8) used for channel B.
REQ-004 Port clk_out_0, input, 1 bit: system clock; all logic is on the rising edge.
REQ-005 Port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 Ports a_valid, a_last, input, 1 bit each: channel A word valid and end-of-frame.
REQ-007 Port a_data, input, 16 bits: channel A word.
REQ-008 Port a_ready, output, 1 bit: channel A word accepted this cycle.
REQ-009 Ports b_valid, b_last, b_data, b_ready: same as the channel A ports, for channel B.
REQ-010 Port flag_full_n, input, 1 bit: FIFO at the addressed endpoint not full (1 = space available).
REQ-011 Port fdata, output, 16 bits: FX2 slave FIFO data bus.
REQ-012 Port faddr, output, 2 bits: FX2 FIFO address.
REQ-013 Ports slwr, slrd, sloe, pkt_end, output, 1 bit each: FX2 strobes, all active-low.
REQ-014 Port grant, output, 1 bit: 0 = channel A owns the FIFO, 1 = channel B owns it.
REQ-015 Port busy, output, 1 bit: 1 whenever the state is not IDLE.

Function
REQ-016 The state machine SHALL have the states IDLE, SETUP, WRITE, COMMIT and GAP.
REQ-017 IDLE: when any valid is high, grant is chosen round-robin, faddr is loaded, and the next state is SETUP.
REQ-018 Round-robin order: on simultaneous requests the channel not served last wins; after reset channel A wins.
REQ-019 SETUP: one cycle of faddr setup with no strobes, then the next state is WRITE.
REQ-020 WRITE: ready of the granted channel = valid & flag_full_n; ready of the other channel = 0.
REQ-021 An accepted word is registered so that fdata = the word and slwr = 0 on the next cycle only; otherwise slwr = 1.
REQ-022 A word counter (0..PKT_WORDS-1) SHALL increment on each accepted word.
REQ-023 When the counter reaches PKT_WORDS words, the counter clears and the next state is GAP.
REQ-024 flag_full_n = 0 or valid = 0 in WRITE stalls the transfer; grant, counter and faddr are held.
REQ-025 COMMIT: pkt_end = 0 for exactly one cycle, coincident with the cycle after the last slwr low, then the next state is GAP.
REQ-026 GAP: one idle cycle, the last-served channel is recorded, then the next state is IDLE.
REQ-027 slrd = 1 and sloe = 1 at all times; the block is write-only.
REQ-028 fdata holds its last value when slwr = 1.

Reset
REQ-029 Assertion of reset_n SHALL immediately force state IDLE, counter 0, grant 0, faddr FADDR_A, fdata 0, slwr 1, pkt_end 1, ready outputs 0 and busy 0.
REQ-030 Reset asserted mid-packet abandons the partial packet; the next packet after release starts with counter 0.

Configuration
REQ-031 With FX2_ARB_PKTEND_EN defined: an accepted word with last = 1 (before PKT_WORDS) clears the counter and the next state is COMMIT (short-packet commit).
REQ-032 With FX2_ARB_PKTEND_EN defined: last on the PKT_WORDS-th word goes to GAP with no pkt_end pulse.
REQ-033 Without FX2_ARB_PKTEND_EN: last is ignored, COMMIT is unreachable, and pkt_end is tied to 1.

Structure
REQ-034 Package fx2_arb_pkg SHALL hold the state enumeration, the default FADDR constants and the PKT_WORDS default.
REQ-035 Sub-module fx2_rr_grant SHALL hold the two-requester round-robin decision with its last-served register.
REQ-036 The top level holds the FSM, the counter and the registered FX2 outputs.

Verification
REQ-037 Only A valid, PKT_WORDS=4, data 1..4: faddr=10; 4 slwr lows carry 1,2,3,4; then GAP; pkt_end stays 1.
REQ-038 A and B valid together with continuous data: packets alternate A,B,A; faddr alternates 10/11; exactly one SETUP cycle precedes each packet.
REQ-039 flag_full_n low for 3 cycles after word 2: ready=0 and slwr=1 for those 3 cycles; words resume at 3; total still 4 words per packet.
REQ-040 Macro defined, a_last on word 2 of 4: 2 writes, then pkt_end low 1 cycle, then GAP; the next A packet starts at counter 0.
REQ-041 Macro undefined, same stimulus as REQ-040: last ignored; the packet continues to 4 words; pkt_end never low.
REQ-042 reset_n low for 1 cycle during word 3: slwr=1 and busy=0 immediately; after release the first packet is full-length, A granted first.
